// File: rtl/psum_pkg.sv
// rtl/psum_pkg.sv - shared types, FSM encoding and saturating-add helper for the psum accumulator
//
// Purpose: types at the default operand/accumulator widths, the accumulator
// state encoding, and a width-generic saturating add. The add works in a
// 64-bit signed container so the accumulator width can be chosen per instance
// (ACC_WIDTH must stay below 64).
// Ports: none (package).
package psum_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ACC_WIDTH  = 32;
  localparam int CALC_W         = 64;

  typedef logic signed [DEF_DATA_WIDTH-1:0]   operand_t;
  typedef logic signed [2*DEF_DATA_WIDTH-1:0] product_t;
  typedef logic signed [DEF_ACC_WIDTH-1:0]    acc_t;

  typedef struct packed {
    acc_t value;
    logic sat;
  } psum_entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  typedef logic signed [CALC_W-1:0] calc_t;

  typedef struct packed {
    calc_t value;
    logic  ovf;
  } sat_result_t;

  // Largest / smallest value representable in a w-bit signed accumulator.
  function automatic calc_t acc_max(input int unsigned w);
    calc_t one;
    one = calc_t'(1);
    return (one << (w - 1)) - one;
  endfunction

  function automatic calc_t acc_min(input int unsigned w);
    calc_t one;
    one = calc_t'(1);
    return -(one << (w - 1));
  endfunction

  localparam acc_t ACC_MAX = acc_t'(acc_max(DEF_ACC_WIDTH));
  localparam acc_t ACC_MIN = acc_t'(acc_min(DEF_ACC_WIDTH));

  // Both inputs are sign-extended values that fit in w bits, so the 64-bit sum
  // itself never wraps; only the clamp to the w-bit range is needed.
  function automatic sat_result_t sat_add(input calc_t acc, input calc_t prod,
                                          input int unsigned w);
    sat_result_t r;
    calc_t       sum;
    sum     = acc + prod;
    r.value = sum;
    r.ovf   = 1'b0;
    if (sum > acc_max(w)) begin
      r.value = acc_max(w);
      r.ovf   = 1'b1;
    end else if (sum < acc_min(w)) begin
      r.value = acc_min(w);
      r.ovf   = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/psum_accumulator_fifo.sv
// rtl/psum_accumulator_fifo.sv - small synchronous FIFO holding completed partial sums
//
// Purpose: DEPTH-entry FIFO of packed {value, sat} psum entries with occupancy
// count. A push while full is accepted only if a pop happens in the same cycle;
// otherwise it is dropped and drop_o pulses. When empty, head_o shows the last
// popped entry (zero after reset).
// Ports:
//   clk_i, rst_i       clock, asynchronous active-high reset
//   push_i, push_data_i  write request and entry
//   pop_i              remove head (ignored when empty)
//   head_o             current head / last popped entry
//   empty_o, full_o    occupancy flags
//   count_o            number of stored entries
//   drop_o             push lost because FIFO was full with no pop
module psum_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     drop_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;

  assign do_pop  = pop_i & ~empty_o;
  // A pop frees the slot in the same cycle, so a full FIFO may still take a push.
  assign do_push = push_i & (~full_o | do_pop);
  assign drop_o  = push_i & full_o & ~do_pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    last_d   = last_q;
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      last_d   = mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
  end

  // Storage needs no reset: it is only visible through head_o while non-empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o = empty_o ? last_q : mem_q[rd_ptr_q];

endmodule

// File: rtl/psum_accumulator.sv
// rtl/psum_accumulator.sv - two-stage multiply/accumulate producing partial sums into an output FIFO
//
// Purpose: multiplies matched IFM/filter byte pairs (stage 1), accumulates the
// products with saturation across chunks (stage 2), and pushes each closed psum
// into a small FIFO. accept_o throttles chunk issue so every started psum has a
// FIFO slot.
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   ifm_data_i, filter_data_i    signed operands, qualified by data_valid_i
//   data_valid_i                 operand pair valid
//   chunk_end_i, last_chunk_i    chunk boundary; last marks the end of the psum
//   accept_o                     upstream may start a chunk
//   psum_o, psum_sat_o           FIFO head value and saturation flag
//   psum_valid_o, psum_ready_i   output handshake
//   overflow_err_o               sticky: psum dropped on a full FIFO
module psum_accumulator
  import psum_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic signed [DATA_WIDTH-1:0] ifm_data_i,
  input  logic signed [DATA_WIDTH-1:0] filter_data_i,
  input  logic                         data_valid_i,
  input  logic                         chunk_end_i,
  input  logic                         last_chunk_i,
  output logic                         accept_o,
  output logic signed [ACC_WIDTH-1:0]  psum_o,
  output logic                         psum_sat_o,
  output logic                         psum_valid_o,
  input  logic                         psum_ready_i,
  output logic                         overflow_err_o
);

  localparam int PROD_W  = 2 * DATA_WIDTH;
  localparam int ENTRY_W = ACC_WIDTH + 1;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

  // Stage 1: registered product and chunk markers.
  logic signed [PROD_W-1:0] prod_q;
  logic                     p_vld_q;
  logic                     end_q;
  logic                     last_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prod_q  <= '0;
      p_vld_q <= 1'b0;
      end_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      prod_q  <= ifm_data_i * filter_data_i;
      p_vld_q <= data_valid_i;
      end_q   <= chunk_end_i;
      last_q  <= chunk_end_i & last_chunk_i;
    end
  end

  // Stage 2: saturating accumulate.
  logic signed [ACC_WIDTH-1:0]       acc_q, acc_d;
  logic                              sat_q, sat_d;
  logic signed [ACC_WIDTH-1:0]       acc_sum;
  logic                              sat_sum;
  logic                              close;
  sat_result_t                       sum_res;
  logic [CALC_W-ACC_WIDTH-1:0]       unused_calc_bits;

  assign close = end_q & last_q;

  always_comb begin
    sum_res = sat_add(calc_t'(acc_q), p_vld_q ? calc_t'(prod_q) : '0, ACC_WIDTH);
    acc_sum = sum_res.value[ACC_WIDTH-1:0];
    sat_sum = sat_q | sum_res.ovf;
    // A closing edge hands the finished sum to the FIFO and restarts from zero,
    // so a pair arriving right after chunk_end lands in the next psum.
    acc_d   = close ? '0 : acc_sum;
    sat_d   = close ? 1'b0 : sat_sum;
  end

  assign unused_calc_bits = sum_res.value[CALC_W-1:ACC_WIDTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      sat_q <= sat_d;
    end
  end

  // Accumulation state: tracks whether a psum is open and thus owns a FIFO slot.
  state_e state_q, state_d;
  logic   pending;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      // A single pair that also closes the psum never enters ACCUM.
      IDLE:    if (!close && p_vld_q) state_d = ACCUM;
      ACCUM:   if (close)             state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pending = (state_q == ACCUM) | close;
  end

  // Output FIFO.
  logic [ENTRY_W-1:0] fifo_head;
  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_empty;
  logic               fifo_full;
  logic               fifo_drop;
  logic               err_q;

  psum_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (close),
    .push_data_i ({acc_sum, sat_sum}),
    .pop_i       (psum_ready_i),
    .head_o      (fifo_head),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full),
    .count_o     (fifo_count),
    .drop_o      (fifo_drop)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= err_q | fifo_drop;
  end

  logic unused_full;
  assign unused_full = fifo_full;

  assign {psum_o, psum_sat_o} = fifo_head;
  assign psum_valid_o         = ~fifo_empty;
  assign overflow_err_o       = err_q;
  assign accept_o             = (int'(fifo_count) + int'(pending)) < FIFO_DEPTH;

endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
- Sits directly downstream of the input selector.
- Consumes matched non-zero IFM/filter byte pairs (data_valid/chunk_end stream) and multiplies them in a registered stage.
- Accumulates products across one or more chunks into a signed partial sum.
- Hands each completed partial sum to the output/requantisation stage through a small valid/ready FIFO, and back-pressures chunk issue when that FIFO cannot absorb another result.

Parameters:
- DATA_WIDTH, 8, width of signed IFM and filter operands.
- ACC_WIDTH, 32, width of signed accumulator and psum output; must be >= 2*DATA_WIDTH+1.
- FIFO_DEPTH, 2, output psum FIFO entries; power of two, >= 2.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- ifm_data_i  in  DATA_WIDTH  signed IFM operand, qualified by data_valid_i
- filter_data_i  in  DATA_WIDTH  signed filter operand, qualified by data_valid_i
- data_valid_i  in  1  operand pair valid this cycle
- chunk_end_i  in  1  current chunk finished; may coincide with data_valid_i
- last_chunk_i  in  1  sampled only with chunk_end_i; 1 = this chunk closes the psum
- accept_o  out  1  upstream may issue chunk_start only while high
- psum_o  out  ACC_WIDTH  FIFO head partial sum
- psum_sat_o  out  1  FIFO head psum saturated
- psum_valid_o  out  1  FIFO non-empty
- psum_ready_i  in  1  consumer pops head when valid&ready
- overflow_err_o  out  1  sticky; push attempted while FIFO full

Behaviour:
- Reset values: psum_o=0, psum_sat_o=0, psum_valid_o=0, accept_o=1, overflow_err_o=0. Accumulator=0, FIFO empty, pipeline valids cleared, state=IDLE. Reset mid-operation discards all in-flight products and FIFO contents.
- Stage 1, edge ending cycle N: prod_r = signed(ifm)*signed(filter), 2*DATA_WIDTH bits; p_vld_r=data_valid_i; end_r=chunk_end_i; last_r=chunk_end_i&last_chunk_i.
- Stage 2, cycle N+1:
  - acc_next = acc_r + (p_vld_r ? sign-extended prod_r : 0).
  - Saturate to ACC_WIDTH signed max/min on overflow; set sat_r sticky for the current psum.
- If end_r&last_r: push {acc_next, sat_next} into FIFO at that edge, then clear acc_r and sat_r to 0. psum_valid_o rises in cycle N+2.
- If end_r&!last_r: acc_r=acc_next; psum carries into the next chunk.
- Products are never dropped between chunks. A data_valid_i in the cycle after chunk_end belongs to the next psum.
- State machine, driven by the stage-1 outputs:
  - IDLE -> ACCUM on p_vld_r.
  - ACCUM -> IDLE on end_r&last_r.
  - ACCUM stays ACCUM on end_r&!last_r.
  - IDLE with end_r&last_r and no data: pushes psum 0 (empty psum is legal).
- FIFO:
  - Simultaneous push and pop when full is allowed; count unchanged.
  - Push when full and no pop: entry dropped, overflow_err_o set. Cleared only by reset.
  - psum_o/psum_sat_o hold the head value while psum_valid_o=1 and ready=0.
  - When empty, psum_o holds the last popped value (0 after reset).
- accept_o = (fifo_count + pending) < FIFO_DEPTH, where pending = 1 while state=ACCUM or a closing end is in stage 1. This guarantees a started psum always has a slot.
- Width rules: operands sign-extended; product exact; only the accumulator saturates. No rounding.

Decomposition:
- Package psum_pkg:
  - typedefs operand_t (signed DATA_WIDTH), product_t (signed 2*DATA_WIDTH), acc_t (signed ACC_WIDTH).
  - struct psum_entry_t {acc_t value; logic sat}.
  - state enum {IDLE, ACCUM}.
  - functions sat_add(acc_t, product_t) and ACC_MAX/ACC_MIN constants.
- Sub-module psum_fifo: parameterised sync FIFO of psum_entry_t with count output, async active-high reset.

Test Plan:
- Single chunk, pairs (3,4),(-2,5),(127,127) with chunk_end+last on the third -> psum_o=16131 valid two cycles after chunk_end, psum_sat_o=0.
- Two chunks: chunk A (10,10) end, last=0; chunk B (-1,50) end, last=1 -> single psum 50. No psum after A.
- ACC_WIDTH=17, repeated (-128,-128) x5, last=1 -> psum_o=65535, psum_sat_o=1. Following psum (1,1) -> 1, sat=0.
- psum_ready_i held 0; close two psums 7 and 9 -> accept_o=0 once the 2nd psum starts, FIFO holds 7 then 9. Pop both -> accept_o=1. Forcing a third close -> overflow_err_o=1.
- Closing end with no data in IDLE -> psum 0 pushed. Same-cycle push+pop at full -> count stays 2, order preserved.
- Assert rst_i mid-accumulation with one entry in the FIFO -> psum_valid_o=0 immediately (async), the next psum starts from 0.
